// File: rtl/apb_pkg.sv
// Shared APB definitions used by the adder master and the wait-state completer.
package apb_pkg;

    localparam int          APB_ADDR_W   = 32;
    localparam int          APB_DATA_W   = 32;
    localparam logic [31:0] ADD_REG_ADDR = 32'h0000_A000;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } apb_slv_state_t;

endpackage

// File: rtl/apb_slv_regbank.sv
// Register array for the APB completer: one write port, one read mux.
module apb_slv_regbank
    import apb_pkg::*;
#(
    parameter int          NUM_REGS  = 4,
    parameter int          IDX_W     = 2,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                  pclk,
    input  logic                  preset_n,
    input  logic                  wr_en_i,
    input  logic [IDX_W-1:0]      wr_idx_i,
    input  logic [APB_DATA_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]      rd_idx_i,
    output logic [APB_DATA_W-1:0] rd_data_o
);

    logic [APB_DATA_W-1:0] regs_q [NUM_REGS];
    logic [APB_DATA_W-1:0] regs_d [NUM_REGS];

    always_comb begin
        regs_d = regs_q;
        if (wr_en_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx_i == IDX_W'(i)) begin
                    regs_d[i] = wr_data_i;
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Loop mux keeps non-power-of-two banks free of out-of-range indexing.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx_i == IDX_W'(i)) begin
                rd_data_o = regs_q[i];
            end
        end
    end

endmodule

// File: rtl/apb_wait_slave.sv
// APB3 completer with programmable wait states, address error
// response and a saturating count of good transfers.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = ADD_REG_ADDR,
    parameter int          NUM_REGS    = 4,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic        pclk,
    input  logic        preset_n,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic [31:0] paddr_i,
    input  logic        pwrite_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic [15:0] acc_cnt_o
);

    localparam int          IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [31:0] SPAN    = 32'(4 * NUM_REGS);
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

    apb_slv_state_t state_q, state_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    logic [31:0]    addr_q, addr_d;
    logic           write_q, write_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [15:0]    acc_cnt_q, acc_cnt_d;

    logic             setup;
    logic             access;
    logic             done;
    logic             legal;
    logic [31:0]      offset;
    logic [IDX_W-1:0] idx;
    logic [31:0]      rd_data;

    assign setup  = psel_i & ~penable_i;
    assign access = psel_i & penable_i;
    assign done   = (state_q == ST_ACCESS) & access & (wait_cnt_q == 4'd0);

    // Decode runs on the captured address so bus changes mid-access are inert.
    assign offset = addr_q - BASE_ADDR;
    assign legal  = (addr_q[1:0] == 2'b00) & (addr_q >= BASE_ADDR)
                  & (offset < SPAN);
    assign idx    = IDX_W'(offset >> 2);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            addr_q     <= 32'h0;
            write_q    <= 1'b0;
            wdata_q    <= 32'h0;
            acc_cnt_q  <= 16'h0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            acc_cnt_q  <= acc_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (setup) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!psel_i || done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        acc_cnt_d  = acc_cnt_q;
        if (state_q == ST_IDLE && setup) begin
            wait_cnt_d = WAIT_LD;
            addr_d     = paddr_i;
            write_d    = pwrite_i;
            wdata_d    = pwdata_i;
        end else if (state_q == ST_ACCESS && access && wait_cnt_q != 4'd0) begin
            wait_cnt_d = wait_cnt_q - 4'd1;
        end
        if (done && legal && acc_cnt_q != 16'hFFFF) begin
            acc_cnt_d = acc_cnt_q + 16'd1;
        end
    end

    always_comb begin
        pready_o  = done;
        pslverr_o = done & ~legal;
        prdata_o  = (done & legal & ~write_q) ? rd_data : 32'h0;
        acc_cnt_o = acc_cnt_q;
    end

    apb_slv_regbank #(
        .NUM_REGS  (NUM_REGS),
        .IDX_W     (IDX_W),
        .RESET_VAL (RESET_VAL)
    ) u_regbank (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .wr_en_i   (done & legal & write_q),
        .wr_idx_i  (idx),
        .wr_data_i (wdata_q),
        .rd_idx_i  (idx),
        .rd_data_o (rd_data)
    );

endmodule

// File: tb/tb_apb_wait_slave.sv
// Scoreboard bench for apb_wait_slave: randomized APB traffic against
// a word-array reference model, plus reset, abort and zero-wait cases.
module tb_apb_wait_slave;
    import apb_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_A000;
    localparam int          NREG  = 4;
    localparam int          WAITC = 2;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b0;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic [15:0] acc_cnt;

    logic        psel0, penable0, pwrite0;
    logic [31:0] paddr0, pwdata0, prdata0;
    logic        pready0, pslverr0;
    logic [15:0] acc_cnt0;

    always #5 pclk = ~pclk;

    apb_wait_slave #(
        .BASE_ADDR(BASE), .NUM_REGS(NREG),
        .WAIT_CYCLES(WAITC), .RESET_VAL(32'h0)
    ) u_dut (
        .pclk(pclk), .preset_n(preset_n),
        .psel_i(psel), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata),
        .prdata_o(prdata), .pready_o(pready),
        .pslverr_o(pslverr), .acc_cnt_o(acc_cnt)
    );

    apb_wait_slave #(
        .BASE_ADDR(BASE), .NUM_REGS(NREG),
        .WAIT_CYCLES(0), .RESET_VAL(32'h0)
    ) u_dut0 (
        .pclk(pclk), .preset_n(preset_n),
        .psel_i(psel0), .penable_i(penable0),
        .paddr_i(paddr0), .pwrite_i(pwrite0), .pwdata_i(pwdata0),
        .prdata_o(prdata0), .pready_o(pready0),
        .pslverr_o(pslverr0), .acc_cnt_o(acc_cnt0)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        slverr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] mem [NREG];
    int          cnt;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic bit is_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a >= BASE) && (a < BASE + 4 * NREG);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mem[i] = 32'h0;
        cnt = 0;
        exp_q.delete();
    endtask

    task automatic model_push(input logic [31:0] a, input logic w,
                              input logic [31:0] d);
        exp_t e;
        int   k;
        if (is_legal(a)) begin
            k = int'((a - BASE) / 4);
            e.slverr = 1'b0;
            e.rdata  = w ? 32'h0 : mem[k];
            if (w) mem[k] = d;
            if (cnt != 65535) cnt++;
        end else begin
            e.slverr = 1'b1;
            e.rdata  = 32'h0;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge pclk) begin
        if (preset_n) begin
            if (pready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pready actual=1 required=0");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("prdata", prdata, mon_e.rdata);
                    check("pslverr", 32'(pslverr), 32'(mon_e.slverr));
                end
            end else begin
                check("idle_pslverr", 32'(pslverr), 32'h0);
                check("idle_prdata", prdata, 32'h0);
            end
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the completing edge.
    task automatic xfer(input logic [31:0] a, input logic w,
                        input logic [31:0] d, output logic [31:0] rd);
        int lat;
        model_push(a, w, d);
        psel = 1'b1; penable = 1'b0;
        paddr = a; pwrite = w; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom);
        lat = 0;
        rd = 32'h0;
        while (lat < 20) begin
            @(negedge pclk);
            lat++;
            if (pready) begin
                rd = prdata;
                break;
            end
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        check("latency", 32'(lat), 32'(WAITC + 1));
        if (lat == 20) exp_q.delete();
        check("acc_cnt", 32'(acc_cnt), 32'(cnt));
    endtask

    task automatic abort(input logic [31:0] a, input logic w,
                         input logic [31:0] d);
        psel = 1'b1; penable = 1'b0;
        paddr = a; pwrite = w; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        check("abort_state", 32'(u_dut.state_q), 32'(ST_IDLE));
        check("abort_acc_cnt", 32'(acc_cnt), 32'(cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, wd, a, v;
        psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
        psel0 = 0; penable0 = 0; pwrite0 = 0; paddr0 = 0; pwdata0 = 0;
        model_reset();

        repeat (3) @(posedge pclk);
        #1;
        check("rst_pready", 32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_prdata", prdata, 32'h0);
        check("rst_acc_cnt", 32'(acc_cnt), 32'h0);
        preset_n = 1'b1;
        @(posedge pclk); #1;

        xfer(BASE, 1'b0, 32'h0, rd);
        xfer(BASE + 4, 1'b1, 32'h1234_5678, rd);
        xfer(BASE + 4, 1'b0, 32'h0, rd);

        // Adder master emulation: read reg0, write it back incremented.
        xfer(BASE, 1'b1, 32'h5, rd);
        xfer(BASE, 1'b0, 32'h0, rd);
        wd = rd + 32'h1;
        check("master_pwdata", wd, 32'h6);
        xfer(BASE, 1'b1, wd, rd);
        xfer(BASE, 1'b0, 32'h0, rd);

        xfer(BASE + 16, 1'b1, $urandom, rd);
        xfer(BASE + 2, 1'b0, 32'h0, rd);
        for (int i = 0; i < NREG; i++) xfer(BASE + 4 * i, 1'b0, 32'h0, rd);

        abort(BASE, 1'b1, 32'h0000_DEAD);
        xfer(BASE, 1'b0, 32'h0, rd);

        for (int n = 0; n < 80; n++) begin
            a = BASE - 8 + 4 * $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) a = a + $urandom_range(1, 3);
            repeat ($urandom_range(0, 2)) @(posedge pclk);
            #0;
            if ($urandom_range(0, 9) == 0) abort(a, 1'($urandom), $urandom);
            else xfer(a, 1'($urandom), $urandom, rd);
        end

        v = $urandom;
        psel0 = 1'b1; penable0 = 1'b0;
        paddr0 = BASE + 12; pwrite0 = 1'b1; pwdata0 = v;
        @(posedge pclk); #1;
        penable0 = 1'b1;
        @(negedge pclk);
        check("w0_pready", 32'(pready0), 32'h1);
        check("w0_pslverr", 32'(pslverr0), 32'h0);
        @(posedge pclk); #1;
        penable0 = 1'b0; pwrite0 = 1'b0;
        @(posedge pclk); #1;
        penable0 = 1'b1;
        @(negedge pclk);
        check("w0_rd_pready", 32'(pready0), 32'h1);
        check("w0_rd_prdata", prdata0, v);
        @(posedge pclk); #1;
        psel0 = 1'b0; penable0 = 1'b0;
        check("w0_acc_cnt", 32'(acc_cnt0), 32'h2);

        psel = 1'b1; penable = 1'b0;
        paddr = BASE + 8; pwrite = 1'b1; pwdata = 32'hCAFE_F00D;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk); #2;
        preset_n = 1'b0;
        #1;
        check("midrst_pready", 32'(pready), 32'h0);
        check("midrst_acc_cnt", 32'(acc_cnt), 32'h0);
        model_reset();
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset_n = 1'b1;
        @(posedge pclk); #1;
        xfer(BASE + 8, 1'b0, 32'h0, rd);
        check("midrst_reg2", rd, 32'h0);

        repeat (2) @(posedge pclk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
